// File: rtl/rtc_bridge_gen2.sv
// PicoBlaze port-bus bridge to a multiplexed address/data RTC chip: zero-wait register
// cache, queued write replay with programmable phase timing, and periodic/irq refresh sweeps.
module rtc_bridge_gen2 #(
    parameter int REG_AW     = 4,
    parameter int FIFO_AW    = 2,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 4,
    parameter int T_HOLD     = 2,
    parameter int REF_FIRST  = 0,
    parameter int REF_LAST   = 8,
    parameter int REF_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipsel,
    input  logic       writestrobe,
    input  logic       readstrobe,
    input  logic [7:0] dir_in,
    input  logic [7:0] dato_in,
    output logic [7:0] data_out_micro,
    input  logic       irq,
    input  logic [7:0] dat_RTC,
    output logic [7:0] data_out,
    output logic       bus_oe,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR
);
    localparam int DEPTH  = 2 ** REG_AW;
    localparam int FDEPTH = 2 ** FIFO_AW;
    localparam int FW     = REG_AW + 8;

    localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_GAP = 2'd3;
    localparam logic [1:0] P_SETUP = 2'd0, P_PULSE = 2'd1, P_HOLD = 2'd2;

    localparam logic [15:0]       TS        = 16'(T_SETUP - 1);
    localparam logic [15:0]       TP        = 16'(T_PULSE - 1);
    localparam logic [15:0]       TH        = 16'(T_HOLD - 1);
    localparam logic [31:0]       PER_MAX   = 32'(REF_PERIOD - 1);
    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(REF_FIRST);
    localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(REF_LAST);
    localparam logic [REG_AW-1:0] IDX_ONE   = 1;
    localparam logic [FIFO_AW:0]  PTR_ONE   = 1;

    logic [7:0]        cache [DEPTH];
    logic [FW-1:0]     fifo_mem [FDEPTH];
    logic [FIFO_AW:0]  wptr, rptr;
    logic              fifo_empty, fifo_full;

    logic [1:0]        state, ph;
    logic [15:0]       cnt;
    logic              cur_wr;
    logic [REG_AW-1:0] cur_addr;
    logic [7:0]        cur_data;

    logic              sweep_act, sweep_pend;
    logic [REG_AW-1:0] ref_idx;
    logic [31:0]       ref_cnt;
    logic              auto_en, ovf, irqf;
    logic              irq_p0, irq_p1, irq_p2;

    logic cpu_wr, cpu_rd, cache_we, ctrl_we, stat_we;
    logic irq_fall, per_hit, trig, ph_last, capture, cap_ok;
    logic start_wr, start_rd, busy;
    logic [7:0] rd_mux;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

    assign cpu_wr   = chipsel & writestrobe;
    assign cpu_rd   = chipsel & readstrobe;
    assign cache_we = cpu_wr & ~dir_in[7];
    assign ctrl_we  = cpu_wr & (dir_in == 8'h80);
    assign stat_we  = cpu_wr & (dir_in == 8'h81);

    assign irq_fall = irq_p2 & ~irq_p1;
    assign per_hit  = auto_en && (ref_cnt == PER_MAX);
    assign trig     = (ctrl_we & dato_in[0]) | per_hit | irq_fall;

    assign ph_last  = (cnt == 16'd0);
    assign capture  = (state == S_DATA) && (ph == P_PULSE) && ph_last && !cur_wr;
    // A CPU write to the index being captured on the same edge takes precedence.
    assign cap_ok   = capture && !(cache_we && (dir_in[REG_AW-1:0] == cur_addr));

    assign start_wr = (state == S_IDLE) && !fifo_empty;
    assign start_rd = (state == S_IDLE) && fifo_empty && sweep_act;
    assign busy     = (state != S_IDLE) || !fifo_empty || sweep_act || sweep_pend;

    always_comb begin
        rd_mux = 8'h00;
        if (!dir_in[7])
            rd_mux = cache[dir_in[REG_AW-1:0]];
        else if (dir_in == 8'h80)
            rd_mux = {6'b0, auto_en, 1'b0};
        else if (dir_in == 8'h81)
            rd_mux = {4'b0, ovf, irqf, fifo_full, busy};
    end

    // Write FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (cache_we && !fifo_full)
            fifo_mem[wptr[FIFO_AW-1:0]] <= {dir_in[REG_AW-1:0], dato_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (cache_we && !fifo_full)
                wptr <= wptr + PTR_ONE;
            if (start_wr)
                rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_act  <= 1'b0;
            sweep_pend <= 1'b0;
            ref_idx    <= FIRST_IDX;
        end else if (start_rd && ref_idx == LAST_IDX) begin
            sweep_act  <= sweep_pend | trig;
            sweep_pend <= 1'b0;
            ref_idx    <= FIRST_IDX;
        end else begin
            if (start_rd)
                ref_idx <= ref_idx + IDX_ONE;
            if (trig) begin
                if (sweep_act) begin
                    sweep_pend <= 1'b1;
                end else begin
                    sweep_act <= 1'b1;
                    ref_idx   <= FIRST_IDX;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ph       <= P_SETUP;
            cnt      <= '0;
            cur_wr   <= 1'b0;
            cur_addr <= '0;
            cur_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_wr) begin
                        cur_wr                <= 1'b1;
                        {cur_addr, cur_data}  <= fifo_mem[rptr[FIFO_AW-1:0]];
                        state                 <= S_ADDR;
                        ph                    <= P_SETUP;
                        cnt                   <= TS;
                    end else if (start_rd) begin
                        cur_wr   <= 1'b0;
                        cur_addr <= ref_idx;
                        cur_data <= '0;
                        state    <= S_ADDR;
                        ph       <= P_SETUP;
                        cnt      <= TS;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (ph_last) begin
                        case (ph)
                            P_SETUP: begin ph <= P_PULSE; cnt <= TP; end
                            P_PULSE: begin ph <= P_HOLD;  cnt <= TH; end
                            default: begin
                                ph    <= P_SETUP;
                                cnt   <= TS;
                                state <= (state == S_ADDR) ? S_DATA : S_GAP;
                            end
                        endcase
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                cache[i] <= 8'h00;
            data_out_micro <= 8'h00;
            auto_en        <= 1'b1;
            ovf            <= 1'b0;
            irqf           <= 1'b0;
            ref_cnt        <= '0;
            irq_p0         <= 1'b1;
            irq_p1         <= 1'b1;
            irq_p2         <= 1'b1;
        end else begin
            irq_p0 <= irq;
            irq_p1 <= irq_p0;
            irq_p2 <= irq_p1;
            if (auto_en)
                ref_cnt <= per_hit ? 32'd0 : ref_cnt + 32'd1;
            if (cap_ok)
                cache[cur_addr] <= dat_RTC;
            if (cache_we)
                cache[dir_in[REG_AW-1:0]] <= dato_in;
            if (ctrl_we)
                auto_en <= dato_in[1];
            if (stat_we) begin
                ovf  <= 1'b0;
                irqf <= 1'b0;
            end
            if (cache_we && fifo_full)
                ovf <= 1'b1;
            if (irq_fall)
                irqf <= 1'b1;
            if (cpu_rd)
                data_out_micro <= rd_mux;
        end
    end

    always_comb begin
        CS       = 1'b1;
        AD       = 1'b1;
        RD       = 1'b1;
        WR       = 1'b1;
        bus_oe   = 1'b0;
        data_out = 8'h00;
        if (state == S_ADDR) begin
            CS       = 1'b0;
            AD       = 1'b0;
            bus_oe   = 1'b1;
            data_out = 8'(cur_addr);
            WR       = (ph != P_PULSE);
        end else if (state == S_DATA) begin
            CS = 1'b0;
            if (cur_wr) begin
                bus_oe   = 1'b1;
                data_out = cur_data;
                WR       = (ph != P_PULSE);
            end else begin
                RD = (ph != P_PULSE);
            end
        end
    end
endmodule

// File: tb/tb_rtc_bridge_gen2.sv
// Directed-plus-random bench for rtc_bridge_gen2: an RTC chip model answers reads with
// base+index, a bus monitor logs transactions, and expectations come from a cache/queue model.
module tb_rtc_bridge_gen2;
    localparam int T_SETUP    = 2;
    localparam int T_PULSE    = 4;
    localparam int T_HOLD     = 2;
    localparam int REF_FIRST  = 0;
    localparam int REF_LAST   = 8;
    localparam int REF_PERIOD = 4000;
    localparam int PH         = T_SETUP + T_PULSE + T_HOLD;

    typedef struct {
        logic wr; logic [7:0] addr; logic [7:0] data;
        int cs_len; int wlo_a; int wlo_d; int rlo; logic oe_err;
    } txn_t;
    typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic chipsel = 1'b0, writestrobe = 1'b0, readstrobe = 1'b0, irq = 1'b1;
    logic [7:0] dir_in = 8'h00, dato_in = 8'h00;
    logic [7:0] dat_RTC, data_out_micro, data_out;
    logic bus_oe, CS, AD, RD, WR;

    logic [7:0] rtc_base = 8'h10;
    logic [7:0] mon_addr = 8'h00;
    logic [7:0] exp_cache [16];
    txn_t mon_q [$];
    exp_t exp_q [$];
    int n_asserts = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign dat_RTC = rtc_base + mon_addr;

    rtc_bridge_gen2 #(
        .REG_AW(4), .FIFO_AW(2), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .REF_FIRST(REF_FIRST), .REF_LAST(REF_LAST), .REF_PERIOD(REF_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .chipsel(chipsel), .writestrobe(writestrobe),
        .readstrobe(readstrobe), .dir_in(dir_in), .dato_in(dato_in),
        .data_out_micro(data_out_micro), .irq(irq), .dat_RTC(dat_RTC),
        .data_out(data_out), .bus_oe(bus_oe), .CS(CS), .AD(AD), .RD(RD), .WR(WR)
    );

    // Bus monitor: one record per CS-low window.
    initial begin
        txn_t cur;
        bit in_txn;
        cur = '{default: 0};
        in_txn = 0;
        forever begin
            @(negedge clk);
            if (!CS) begin
                in_txn = 1;
                cur.cs_len++;
                if (!AD) begin
                    cur.addr = data_out;
                    mon_addr = data_out;
                    if (!WR) cur.wlo_a++;
                    if (!bus_oe) cur.oe_err = 1;
                end else begin
                    if (!WR) begin
                        cur.wlo_d++;
                        cur.wr = 1;
                        cur.data = data_out;
                        if (!bus_oe) cur.oe_err = 1;
                    end
                    if (!RD) begin
                        cur.rlo++;
                        if (bus_oe) cur.oe_err = 1;
                    end
                end
            end else if (in_txn) begin
                mon_q.push_back(cur);
                cur = '{default: 0};
                in_txn = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        chipsel = 1; writestrobe = 1; dir_in = a; dato_in = d;
        if (!a[7]) exp_cache[a[3:0]] = d;
        @(negedge clk);
        chipsel = 0; writestrobe = 0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        chipsel = 1; readstrobe = 1; dir_in = a;
        @(negedge clk);
        chipsel = 0; readstrobe = 0;
        d = data_out_micro;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        logic [7:0] s;
        cycles = 0;
        do begin
            cpu_read(8'h81, s);
            cycles++;
        end while (s[0] && cycles < budget);
        chk("idle_within_budget", 32'(s[0]), 0);
    endtask

    task automatic exp_push(input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_sweep(input int from_idx);
        for (int i = from_idx; i <= REF_LAST; i++) begin
            exp_push(1'b0, 8'(i), 8'h00);
            exp_cache[i] = 8'(rtc_base + 8'(i));
        end
    endtask

    task automatic chk_txns(input string tag);
        txn_t t;
        chk({tag, "_txn_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            t = mon_q[i];
            chk($sformatf("%s_txn%0d_kind_addr", tag, i), {t.wr, t.addr}, {exp_q[i].wr, exp_q[i].addr});
            if (exp_q[i].wr)
                chk($sformatf("%s_txn%0d_data", tag, i), t.data, exp_q[i].data);
            chk($sformatf("%s_txn%0d_timing", tag, i),
                {8'(t.cs_len), 8'(t.wlo_a), 8'(t.wlo_d), 7'(t.rlo), t.oe_err},
                {8'(2 * PH), 8'(T_PULSE), exp_q[i].wr ? 8'(T_PULSE) : 8'd0,
                 exp_q[i].wr ? 7'd0 : 7'(T_PULSE), 1'b0});
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cache(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            cpu_read(8'(i), v);
            chk($sformatf("%s_cache%0d", tag, i), v, exp_cache[i]);
        end
    endtask

    task automatic wait_rd_low(input string tag);
        int k;
        k = 0;
        while (RD && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rd_seen"}, 32'(RD), 0);
    endtask

    initial begin
        logic [7:0] v, a, d;
        int n, k;
        for (int i = 0; i < 16; i++) exp_cache[i] = 8'h00;

        repeat (3) @(negedge clk);
        reset = 0;
        // Reset state
        chk("rst_strobes", {CS, AD, RD, WR}, 4'hF);
        chk("rst_bus_oe", bus_oe, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_out_micro", data_out_micro, 0);
        cpu_read(8'h81, v); chk("rst_stat", v, 8'h00);
        cpu_read(8'h03, v); chk("rst_cache3", v, 8'h00);
        cpu_read(8'h80, v); chk("rst_ctrl", v, 8'h02);
        cpu_write(8'h80, 8'h00);
        cpu_read(8'h80, v); chk("ctrl_auto_off", v, 8'h00);

        // Single write: write-through cache, then bus replay
        cpu_write(8'h02, 8'h55);
        cpu_read(8'h02, v); chk("wt_cache2", v, 8'h55);
        chk("wt_bus_active", CS, 0);
        exp_push(1'b1, 8'h02, 8'h55);
        wait_idle(100, n);
        chk_txns("single");

        // Random bursts that never overflow the FIFO
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                a = {1'b0, 3'($urandom), 4'($urandom)};
                d = 8'($urandom);
                cpu_write(a, d);
                exp_push(1'b1, {4'h0, a[3:0]}, d);
            end
            wait_idle(200, n);
            chk_txns($sformatf("rnd%0d", r));
            for (int j = 0; j < 4; j++) begin
                a = 8'($urandom_range(0, 15));
                cpu_read(a, v);
                chk($sformatf("rnd%0d_rb%0d", r, j), v, exp_cache[a[3:0]]);
            end
        end

        // Overflow: one write on the bus, four queued, one dropped
        for (int j = 0; j < 6; j++) begin
            cpu_write(8'(10 + j), 8'(8'hA0 + 8'(j)));
            if (j < 5) exp_push(1'b1, 8'(10 + j), 8'(8'hA0 + 8'(j)));
        end
        cpu_read(8'h81, v); chk("ovf_stat_full", v, 8'h0B);
        cpu_write(8'h81, 8'h00);
        cpu_read(8'h81, v); chk("ovf_cleared", v, 8'h03);
        wait_idle(200, n);
        chk_txns("ovf");
        cpu_read(8'h0F, v); chk("ovf_dropped_cached", v, 8'hA5);
        cpu_read(8'h81, v); chk("ovf_stat_idle", v, 8'h00);

        // Software refresh sweep
        rtc_base = 8'($urandom);
        cpu_write(8'h80, 8'h01);
        exp_sweep(REF_FIRST);
        wait_idle(400, n);
        chk("sweep_cycles", 32'(n >= 9 * (2 * PH + 1) && n <= 9 * (2 * PH + 2) + 3), 1);
        chk_txns("sweep");
        chk_cache("sweep");

        // irq falling edge during a queued write
        rtc_base = 8'($urandom);
        d = 8'($urandom);
        cpu_write(8'h05, d);
        exp_push(1'b1, 8'h05, d);
        repeat (3) @(negedge clk);
        irq = 0;
        repeat (3) @(negedge clk);
        irq = 1;
        exp_sweep(REF_FIRST);
        wait_idle(400, n);
        chk_txns("irq");
        cpu_read(8'h81, v); chk("irq_flag", v, 8'h04);
        cpu_write(8'h81, 8'h00);
        cpu_read(8'h81, v); chk("irq_flag_clr", v, 8'h00);
        chk_cache("irq");

        // CPU write lands on the capture edge of a refresh read
        rtc_base = 8'($urandom);
        cpu_write(8'h80, 8'h01);
        wait_rd_low("col");
        repeat (3) @(negedge clk);
        d = 8'($urandom);
        cpu_write(8'h00, d);
        exp_push(1'b0, 8'h00, 8'h00);
        exp_push(1'b1, 8'h00, d);
        exp_sweep(REF_FIRST + 1);
        wait_idle(400, n);
        chk_txns("col");
        chk("col_cpu_wins", exp_cache[0], d);
        chk_cache("col");

        // Reset in the middle of a read strobe
        rtc_base = 8'($urandom);
        cpu_write(8'h80, 8'h01);
        wait_rd_low("rst");
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_strobes", {CS, AD, RD, WR}, 4'hF);
        chk("midrst_bus_oe", bus_oe, 0);
        reset = 0;
        for (int i = 0; i < 16; i++) exp_cache[i] = 8'h00;
        cpu_read(8'h81, v); chk("midrst_stat", v, 8'h00);
        cpu_read(8'h00, v); chk("midrst_entry_untouched", v, 8'h00);
        cpu_read(8'h80, v); chk("midrst_ctrl", v, 8'h02);
        mon_q.delete();
        exp_q.delete();

        // Periodic refresh with auto_en restored by reset
        rtc_base = 8'($urandom);
        repeat (REF_PERIOD - 150) @(negedge clk);
        chk("auto_not_early", 32'(mon_q.size()), 0);
        repeat (300) @(negedge clk);
        wait_idle(400, n);
        exp_sweep(REF_FIRST);
        chk_txns("auto");
        chk_cache("auto");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
